// File: rtl/madd_divider.sv
// Multiply-add decomposer: given D = A*B + C + R, recovers the quotient A
// and remainder R (R < B) using a restoring divider that retires one
// quotient bit per clock. Operands are captured on the start handshake, so
// later input changes do not disturb a running operation.

package argum;
    parameter int size          = 8;
    parameter int DATA_OUT_size = 16;
endpackage

module madd_divider #(
    parameter int size          = argum::size,
    parameter int DATA_OUT_size = argum::DATA_OUT_size
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [DATA_OUT_size-1:0] DATA_IN,
    input  logic [size-1:0]          B,
    input  logic [size-1:0]          C,
    output logic                     ready,
    output logic                     done,
    output logic [size-1:0]          A,
    output logic [size-1:0]          R,
    output logic                     ERR
);

    localparam int CW = (size > 1) ? $clog2(size) : 1;
    localparam int HW = DATA_OUT_size - size;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Captured operands
    logic [DATA_OUT_size-1:0] dat_q, dat_d;
    logic [size-1:0]          div_q, div_d;
    logic [size-1:0]          add_q, add_d;

    // Divider datapath: remaining low dividend bits, partial remainder,
    // quotient being built and iteration counter
    logic [size-1:0] low_q, low_d;
    logic [size-1:0] rem_q, rem_d;
    logic [size-1:0] quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Registered outputs
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic [size-1:0] a_q, a_d;
    logic [size-1:0] r_q, r_d;
    logic            err_q, err_d;

    // Combinational helpers for the SUB and DIV steps
    logic [DATA_OUT_size-1:0] diff;
    logic [HW-1:0]            diffHi;
    logic                     badOp;
    logic [size:0]            shifted;
    logic                     fits;
    logic [size-1:0]          remNext;
    logic [size-1:0]          quoNext;

    // Datapath arithmetic shared by the SUB check and each DIV iteration
    always_comb begin
        diff    = dat_q - {{HW{1'b0}}, add_q};
        diffHi  = diff[DATA_OUT_size-1:size];
        badOp   = (div_q == '0)
               || (dat_q < {{HW{1'b0}}, add_q})
               || (diffHi >= {{(HW-size){1'b0}}, div_q});
        shifted = {rem_q, low_q[size-1]};
        fits    = (shifted >= {1'b0, div_q});
        remNext = fits ? (shifted[size-1:0] - div_q) : shifted[size-1:0];
        quoNext = {quo_q[size-2:0], fits};
    end

    // Next-state and next-output logic for the IDLE/SUB/DIV/DONE sequence
    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        div_d   = div_q;
        add_d   = add_q;
        low_d   = low_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        r_d     = r_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dat_d   = DATA_IN;
                    div_d   = B;
                    add_d   = C;
                    state_d = SUB;
                end
            end
            SUB: begin
                if (badOp) begin
                    a_d     = '0;
                    r_d     = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    rem_d   = diffHi[size-1:0];
                    low_d   = diff[size-1:0];
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d = remNext;
                quo_d = quoNext;
                low_d = {low_q[size-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(size - 1)) begin
                    a_d     = quoNext;
                    r_d     = remNext;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

    // State, datapath and output registers with asynchronous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dat_q   <= '0;
            div_q   <= '0;
            add_q   <= '0;
            low_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            a_q     <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            div_q   <= div_d;
            add_q   <= add_d;
            low_q   <= low_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            a_q     <= a_d;
            r_q     <= r_d;
            err_q   <= err_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign A     = a_q;
    assign R     = r_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_madd_divider.sv
// Bench for madd_divider: directed cases with literal expectations, reset
// abort, ignored start, and randomized back-to-back operations, all compared
// every cycle against an arithmetic reference model.

module tb_madd_divider;

    localparam int SZ = 8;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] DATA_IN = '0;
    logic [SZ-1:0] B = '0;
    logic [SZ-1:0] C = '0;
    logic          ready;
    logic          done;
    logic [SZ-1:0] A;
    logic [SZ-1:0] R;
    logic          ERR;

    int total = 0;
    int bad = 0;
    bit checkOn = 1'b0;

    madd_divider dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .DATA_IN (DATA_IN),
        .B       (B),
        .C       (C),
        .ready   (ready),
        .done    (done),
        .A       (A),
        .R       (R),
        .ERR     (ERR)
    );

    // Free-running clock, 10 time units per period
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference arithmetic: D - C split into quotient and remainder by B
    function automatic void refModel(input logic [DW-1:0] d, input logic [SZ-1:0] b,
                                     input logic [SZ-1:0] c, output logic [SZ-1:0] qa,
                                     output logic [SZ-1:0] qr, output logic qe);
        int diff;
        diff = int'(d) - int'(c);
        if (b == 0 || diff < 0) begin
            qe = 1'b1; qa = '0; qr = '0;
        end else if (diff / int'(b) > (1 << SZ) - 1) begin
            qe = 1'b1; qa = '0; qr = '0;
        end else begin
            qe = 1'b0;
            qa = SZ'(diff / int'(b));
            qr = SZ'(diff % int'(b));
        end
    endfunction

    // Transaction-level model: accept when idle, present the result after
    // the fixed latency, then become idle again one cycle later
    bit            mBusy = 1'b0;
    bit            expDone = 1'b0;
    int            mEdge = 0;
    int            mLat = 0;
    logic [SZ-1:0] pA = '0, pR = '0;
    logic          pE = 1'b0;
    logic [SZ-1:0] expA = '0, expR = '0;
    logic          expErr = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mBusy = 1'b0; expDone = 1'b0; mEdge = 0;
            expA = '0; expR = '0; expErr = 1'b0;
        end else if (!mBusy) begin
            expDone = 1'b0;
            if (start) begin
                refModel(DATA_IN, B, C, pA, pR, pE);
                mLat  = pE ? 1 : SZ + 1;
                mEdge = 0;
                mBusy = 1'b1;
            end
        end else begin
            mEdge++;
            expDone = (mEdge == mLat);
            if (expDone) begin
                expA = pA; expR = pR; expErr = pE;
            end
            if (mEdge == mLat + 1) mBusy = 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (checkOn) begin
            checkOutput("cyc_ready", 32'(ready), 32'(!mBusy));
            checkOutput("cyc_done",  32'(done),  32'(expDone));
            checkOutput("cyc_A",     32'(A),     32'(expA));
            checkOutput("cyc_R",     32'(R),     32'(expR));
            checkOutput("cyc_ERR",   32'(ERR),   32'(expErr));
        end
    end

    // One start pulse, then scramble inputs while waiting for done;
    // optionally re-pulse start mid-operation
    task automatic applyStimulus(input logic [DW-1:0] d, input logic [SZ-1:0] b,
                                 input logic [SZ-1:0] c, input bit poke, output int lat);
        @(negedge clock);
        DATA_IN = d; B = b; C = c; start = 1'b1;
        @(posedge clock);
        lat = 0;
        while (lat < 40) begin
            @(negedge clock);
            lat++;
            if (done) break;
            start   = (poke && lat == 4);
            DATA_IN = DW'($urandom);
            B       = SZ'($urandom);
            C       = SZ'($urandom);
        end
        start = 1'b0;
    endtask

    // Directed operation with literal expected latency and results
    task automatic directedOp(input string name, input logic [DW-1:0] d, input logic [SZ-1:0] b,
                              input logic [SZ-1:0] c, input bit poke, input int eLat,
                              input logic [SZ-1:0] eA, input logic [SZ-1:0] eR, input logic eE);
        int lat;
        applyStimulus(d, b, c, poke, lat);
        checkOutput({name, "_lat"}, 32'(lat), 32'(eLat));
        checkOutput({name, "_A"},   32'(A),   32'(eA));
        checkOutput({name, "_R"},   32'(R),   32'(eR));
        checkOutput({name, "_ERR"}, 32'(ERR), 32'(eE));
    endtask

    // Global watchdog
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [SZ-1:0] qa, qr;
        logic          qe;
        int            extra;
        int            lat;
        int            ra, rb, rc, rr;

        // Pin the reference model with hand-computed values
        refModel(16'd200, 8'd12, 8'd8, qa, qr, qe);
        checkOutput("model_200_A", 32'(qa), 32'd16);
        checkOutput("model_200_R", 32'(qr), 32'd0);
        refModel(16'd205, 8'd12, 8'd8, qa, qr, qe);
        checkOutput("model_205_R", 32'(qr), 32'd5);
        refModel(16'd65535, 8'd1, 8'd0, qa, qr, qe);
        checkOutput("model_ovf_E", 32'(qe), 32'd1);
        refModel(16'd5, 8'd3, 8'd10, qa, qr, qe);
        checkOutput("model_neg_E", 32'(qe), 32'd1);

        // Asynchronous reset, checked before any clock edge acts on it
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(ready), 32'd1);
        checkOutput("rst_done",  32'(done),  32'd0);
        checkOutput("rst_A",     32'(A),     32'd0);
        checkOutput("rst_R",     32'(R),     32'd0);
        checkOutput("rst_ERR",   32'(ERR),   32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        checkOn = 1'b1;

        // Directed normal and error cases
        directedOp("d200",  16'd200,   8'd12,  8'd8,   1'b0, SZ + 2, 8'd16,  8'd0, 1'b0);
        directedOp("d205",  16'd205,   8'd12,  8'd8,   1'b0, SZ + 2, 8'd16,  8'd5, 1'b0);
        directedOp("dmax",  16'd65280, 8'd255, 8'd255, 1'b0, SZ + 2, 8'd255, 8'd0, 1'b0);
        directedOp("eB0",   16'd100,   8'd0,   8'd3,   1'b0, 2,      8'd0,   8'd0, 1'b1);
        directedOp("eDltC", 16'd5,     8'd7,   8'd10,  1'b0, 2,      8'd0,   8'd0, 1'b1);
        directedOp("eOvf",  16'd65535, 8'd1,   8'd0,   1'b0, 2,      8'd0,   8'd0, 1'b1);
        directedOp("dfix",  16'd1000,  8'd7,   8'd3,   1'b0, SZ + 2, 8'd142, 8'd3, 1'b0);

        // Start re-pulsed during DIV must be ignored: one done only
        directedOp("poke",  16'd200,   8'd12,  8'd8,   1'b1, SZ + 2, 8'd16,  8'd0, 1'b0);
        extra = 0;
        repeat (2 * SZ) begin
            @(negedge clock);
            if (done) extra++;
        end
        checkOutput("poke_extra_done", 32'(extra), 32'd0);

        // Reset in the middle of DIV aborts without a done pulse
        @(negedge clock);
        DATA_IN = 16'd1000; B = 8'd7; C = 8'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("abort_ready", 32'(ready), 32'd1);
        checkOutput("abort_done",  32'(done),  32'd0);
        checkOutput("abort_A",     32'(A),     32'd0);
        checkOutput("abort_R",     32'(R),     32'd0);
        checkOutput("abort_ERR",   32'(ERR),   32'd0);
        extra = 0;
        repeat (2) begin
            @(negedge clock);
            if (done) extra++;
        end
        checkOutput("abort_no_done", 32'(extra), 32'd0);
        reset_n = 1'b1;
        directedOp("after_rst", 16'd200, 8'd12, 8'd8, 1'b0, SZ + 2, 8'd16, 8'd0, 1'b0);

        // Random well-formed operands with start held high back-to-back
        @(negedge clock);
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(1, 255));
            rc = int'($urandom_range(0, 255));
            rr = int'($urandom_range(0, rb - 1));
            DATA_IN = DW'(ra * rb + rc + rr);
            B = SZ'(rb);
            C = SZ'(rc);
            lat = 0;
            while (lat < 40) begin
                @(negedge clock);
                lat++;
                if (done) break;
            end
            checkOutput("rnd_seen", 32'(done), 32'd1);
            checkOutput("rnd_A",    32'(A),    32'(ra));
            checkOutput("rnd_R",    32'(R),    32'(rr));
            checkOutput("rnd_ERR",  32'(ERR),  32'd0);
        end
        start = 1'b0;

        // Random raw operands, including invalid ones, against the model
        for (int i = 0; i < 20; i++) begin
            logic [DW-1:0] rd;
            logic [SZ-1:0] rbb, rcc;
            rd  = DW'($urandom);
            rbb = SZ'($urandom_range(0, 15));
            rcc = SZ'($urandom);
            refModel(rd, rbb, rcc, qa, qr, qe);
            applyStimulus(rd, rbb, rcc, 1'b0, lat);
            checkOutput("raw_lat", 32'(lat), qe ? 32'd2 : 32'(SZ + 2));
        end

        repeat (4) @(negedge clock);
        checkOn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
